// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 single-wire link.
//   - default pulse/gap thresholds (in clk cycles) for 12 MHz and 16 MHz clocks
//   - BITS_PER_LED: bits in one GRB/RGB word
//   - state_t: receive FSM state encoding
package ws2812_pkg;

    localparam int BITS_PER_LED = 24;

    // 12 MHz: 0-bit high ~5 cycles, 1-bit high ~10 cycles, 50 us reset gap.
    localparam int T12_MIN_HIGH  = 2;
    localparam int T12_THRESH    = 8;
    localparam int T12_MAX_HIGH  = 20;
    localparam int T12_RESET_MIN = 600;

    // 16 MHz: same pulse widths scaled by 4/3.
    localparam int T16_MIN_HIGH  = 3;
    localparam int T16_THRESH    = 11;
    localparam int T16_MAX_HIGH  = 27;
    localparam int T16_RESET_MIN = 800;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

endpackage

// File: rtl/ws2812_rx_sync2.sv
// sync2: two-flop synchronizer for asynchronous inputs, reset to 0.
//   clk   : destination clock
//   reset : asynchronous, active-high
//   d     : asynchronous input (W bits, each synchronized independently)
//   q     : synchronized output, 2 clk edges after d
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 line decoder. Classifies each high pulse on the
// synchronized line as a 0/1 bit, assembles MSB-first 24-bit words and
// reports each with its LED index (counting down from NUM_LEDS-1).
//   clk        : system clock
//   reset      : asynchronous, active-high
//   din        : raw WS2812 line, asynchronous to clk
//   rgb_data   : last completed word
//   led_num    : LED index of rgb_data
//   valid      : 1-cycle strobe, rgb_data/led_num updated
//   frame_done : 1-cycle strobe, clean frame end
//   frame_err  : 1-cycle strobe, protocol error
//   overflow   : sticky, more than NUM_LEDS words in a frame
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int T_MIN_HIGH  = T12_MIN_HIGH,
    parameter int T_THRESH    = T12_THRESH,
    parameter int T_MAX_HIGH  = T12_MAX_HIGH,
    parameter int T_RESET_MIN = T12_RESET_MIN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic        overflow
);

    localparam logic [9:0] L_MIN_HIGH  = 10'(T_MIN_HIGH);
    localparam logic [9:0] L_THRESH    = 10'(T_THRESH);
    localparam logic [9:0] L_MAX_HIGH  = 10'(T_MAX_HIGH);
    localparam logic [9:0] L_RESET     = 10'(T_RESET_MIN);
    localparam logic [7:0] L_NUM       = 8'(NUM_LEDS);
    localparam logic [4:0] L_LAST_BIT  = 5'(BITS_PER_LED - 1);

    logic        w_din_s;
    logic        w_bit;
    logic [9:0]  w_cnt_inc;

    state_t      r_state;
    logic [9:0]  r_cnt;
    logic [4:0]  r_bit_idx;
    logic [7:0]  r_word_idx;
    // Only the 23 bits before the current one are kept; the final bit of a
    // word is merged straight into rgb_data.
    logic [22:0] r_shreg;
    logic [23:0] r_rgb_data;
    logic [7:0]  r_led_num;
    logic        r_valid;
    logic        r_frame_done;
    logic        r_frame_err;
    logic        r_overflow;

    sync2 #(.W(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (w_din_s)
    );

    assign w_bit     = (r_cnt >= L_THRESH);
    assign w_cnt_inc = (r_cnt == 10'h3FF) ? r_cnt : r_cnt + 10'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SYNC;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_word_idx   <= '0;
            r_shreg      <= '0;
            r_rgb_data   <= '0;
            r_led_num    <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                // Wait for a full reset-length low gap before decoding.
                ST_SYNC: begin
                    if (w_din_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt >= L_RESET) begin
                        r_state    <= ST_IDLE;
                        r_bit_idx  <= '0;
                        r_word_idx <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_IDLE: begin
                    if (w_din_s) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= 10'd1;
                    end
                end
                ST_HIGH: begin
                    if (w_din_s) begin
                        // Another high sample would push the width past the limit.
                        if (r_cnt >= L_MAX_HIGH) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_SYNC;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else if (r_cnt < L_MIN_HIGH) begin
                        r_frame_err <= 1'b1;
                        r_state     <= ST_SYNC;
                        r_cnt       <= '0;
                    end else begin
                        r_shreg <= {r_shreg[21:0], w_bit};
                        r_state <= ST_LOW;
                        r_cnt   <= 10'd1;
                        if (r_bit_idx == L_LAST_BIT) begin
                            r_bit_idx <= '0;
                            if (r_word_idx < L_NUM) begin
                                r_rgb_data <= {r_shreg, w_bit};
                                r_led_num  <= L_NUM - 8'd1 - r_word_idx;
                                r_valid    <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                            if (r_word_idx != 8'hFF)
                                r_word_idx <= r_word_idx + 8'd1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 5'd1;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_din_s) begin
                        r_state <= ST_HIGH;
                        r_cnt   <= 10'd1;
                    end else if (r_cnt >= L_RESET) begin
                        if (r_bit_idx == '0 && r_word_idx != '0) begin
                            r_frame_done <= 1'b1;
                            // An overflowing frame keeps the flag set through its
                            // own frame_done; the next frame that fits clears it.
                            r_overflow   <= (r_word_idx > L_NUM);
                        end else if (r_bit_idx != '0) begin
                            r_frame_err <= 1'b1;
                        end
                        r_state    <= ST_IDLE;
                        r_bit_idx  <= '0;
                        r_word_idx <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_SYNC;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rgb_data   = r_rgb_data;
    assign led_num    = r_led_num;
    assign valid      = r_valid;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule
